uart_tx_src_arbiter: RTL and testbench

- Parametrised, registered successor to the combinational tx source mux.
- Selects one of N_CH word sources (register file taps, status words, constants) and hands the word to the UART tx framer over a valid/ready handshake.
- Arbitration is fixed-priority or round-robin. The output word is held stable until the framer accepts it.
- Sits between the core-side data sources and the UART tx serializer.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/rr_priority_picker.sv | 58 +++++
 rtl/uart_tx_src_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_src_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared state encoding, arbitration modes and width helper for
//            the UART tx source arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef logic [0:0] state_t;

    // Index width that never collapses to zero for a single channel.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational rotating-priority picker; first request found at
//            or after start_i (wrapping) wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import uart_tx_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PTR_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    localparam int OW = PTR_W + 1;

    logic [2*N_CH-1:0] w_rot;
    logic [OW-1:0]     w_off;
    logic [OW-1:0]     w_sum;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search after rotation.
    assign w_rot = {req_i, req_i} >> start_i;

    always_comb begin
        w_off = '0;
        for (int k = 2*N_CH-1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = OW'(k);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, start_i} + w_off;
        if (w_sum >= OW'(N_CH)) begin
            w_sum = w_sum - OW'(N_CH);
        end
    end

    assign any_o = |req_i;
    assign idx_o = w_sum[PTR_W-1:0];

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_o[i] = any_o && (w_sum == OW'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_src_arbiter
// Purpose  : Registered N-way word source arbiter feeding the UART tx framer
//            over a valid/ready handshake (fixed priority or round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_src_arbiter
    import uart_tx_pkg::*;
#(
    parameter int LENGTH  = 32,
    parameter int N_CH    = 4,
    parameter int RR_MODE = 1,
    parameter int CH_W    = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [N_CH-1:0]        src_valid,
    input  logic [N_CH*LENGTH-1:0] src_data,
    output logic [N_CH-1:0]        src_ready,
    output logic                   out_valid,
    output logic [LENGTH-1:0]      out_data,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        grant_id,
    output logic                   busy
);

    logic [0:0]        state_q, state_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic [CH_W-1:0]   gid_q, gid_d;

    logic [CH_W-1:0]   w_start;
    logic [N_CH-1:0]   w_oh;
    logic [CH_W-1:0]   w_idx;
    logic              w_any;
    logic              w_fire;
    logic [LENGTH-1:0] w_sel;

    rr_priority_picker #(
        .N_CH  (N_CH),
        .PTR_W (CH_W)
    ) u_picker (
        .req_i   (src_valid),
        .start_i (w_start),
        .grant_o (w_oh),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    // Gated by rst so no accept pulse leaks out while reset is held.
    assign w_fire = rst & enable & w_any & (state_q == ST_IDLE);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_oh[i]) begin
                w_sel = src_data[i*LENGTH +: LENGTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    state_d = ST_SEND;
                    data_d  = w_sel;
                    gid_d   = w_idx;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

    generate
        if (RR_MODE == ARB_RR && N_CH > 1) begin : g_rr
            logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (w_fire) begin
                    rr_ptr_d = (w_idx == CH_W'(N_CH-1)) ? '0 : w_idx + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end

            assign w_start = rr_ptr_q;
        end else begin : g_fixed
            assign w_start = '0;
        end
    endgenerate

    assign src_ready = w_fire ? w_oh : '0;
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign out_data  = data_q;
    assign grant_id  = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_src_arbiter
// Purpose  : Self-checking bench driving a fixed-priority and a round-robin
//            arbiter side by side from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_src_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             out_ready;
    logic [3:0]       src_valid;
    logic [127:0]     src_data;
    logic [1:0][3:0]  sr;
    logic [1:0]       ov;
    logic [1:0]       bz;
    logic [1:0][31:0] od;
    logic [1:0][1:0]  gid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Index 0 = fixed priority, index 1 = round-robin.
    uart_tx_src_arbiter #(.LENGTH(32), .N_CH(4), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid),
        .src_data(src_data), .src_ready(sr[0]), .out_valid(ov[0]),
        .out_data(od[0]), .out_ready(out_ready), .grant_id(gid[0]), .busy(bz[0])
    );

    uart_tx_src_arbiter #(.LENGTH(32), .N_CH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid),
        .src_data(src_data), .src_ready(sr[1]), .out_valid(ov[1]),
        .out_data(od[1]), .out_ready(out_ready), .grant_id(gid[1]), .busy(bz[1])
    );

    function automatic int pick(input logic [3:0] v, input int start);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (v[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        src_valid = 4'b0;
        out_ready = 1'b0;
        enable    = 1'b1;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        src_valid = 4'b1111;
        src_data  = {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if ({ov[m], bz[m], sr[m], od[m], gid[m]} !== 40'd0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got ov=%b bz=%b sr=%b od=%h gid=%0d expected all zero",
                         m, ov[m], bz[m], sr[m], od[m], gid[m]);
            end
        end
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (sr[m] !== 4'b0001) begin
                n_err++;
                $display("FAIL reset_release_ready[%0d]: got %b expected 0001", m, sr[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if ({ov[m], gid[m], od[m]} !== {1'b1, 2'd0, 32'hA0A0_0000}) begin
                n_err++;
                $display("FAIL reset_first_grant[%0d]: got ov=%b gid=%0d od=%h expected 1 0 a0a00000",
                         m, ov[m], gid[m], od[m]);
            end
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        src_data  = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};
        src_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if (sr[m] !== 4'b0100) begin
                n_err++;
                $display("FAIL single_ready[%0d]: got %b expected 0100", m, sr[m]);
            end
        end
        tick();
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if ({ov[m], od[m], gid[m], sr[m]} !== {1'b1, 32'hA5A5_0002, 2'd2, 4'b0}) begin
                n_err++;
                $display("FAIL single_out[%0d]: got ov=%b od=%h gid=%0d sr=%b expected 1 a5a50002 2 0000",
                         m, ov[m], od[m], gid[m], sr[m]);
            end
        end
        tick();
        n_vec++;
        if (ov !== 2'b00) begin
            n_err++;
            $display("FAIL single_drop: got out_valid=%b expected 00", ov);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        src_data  = {32'h0, 32'h0, 32'h1111_0001, 32'h0};
        src_valid = 4'b0010;
        out_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            src_data[63:32] = $urandom;
            #1;
            for (int m = 0; m < 2; m++) begin
                n_vec++;
                if ({bz[m], ov[m], sr[m], od[m], gid[m]} !== {2'b11, 4'b0, 32'h1111_0001, 2'd1}) begin
                    n_err++;
                    $display("FAIL backpressure_hold[%0d] c%0d: got bz=%b ov=%b sr=%b od=%h gid=%0d expected 1 1 0000 11110001 1",
                             m, c, bz[m], ov[m], sr[m], od[m], gid[m]);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        src_valid = 4'b0;
        tick();
        n_vec++;
        if ({bz, ov} !== 4'b0) begin
            n_err++;
            $display("FAIL backpressure_release: got bz=%b ov=%b expected 00 00", bz, ov);
        end
    endtask

    task automatic test_rr_fairness();
        do_reset();
        src_valid = 4'b1111;
        out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            n_vec++;
            if (sr[1] !== 4'(1 << (g % 4)) || sr[0] !== 4'b0001) begin
                n_err++;
                $display("FAIL rr_ready g%0d: got rr=%b fx=%b expected rr=%b fx=0001",
                         g, sr[1], sr[0], 4'(1 << (g % 4)));
            end
            tick();
            n_vec++;
            if (gid[1] !== 2'(g % 4) || gid[0] !== 2'd0 || ov !== 2'b11) begin
                n_err++;
                $display("FAIL rr_grant g%0d: got rr=%0d fx=%0d ov=%b expected rr=%0d fx=0 ov=11",
                         g, gid[1], gid[0], ov, g % 4);
            end
            tick();
            n_vec++;
            if (ov !== 2'b00) begin
                n_err++;
                $display("FAIL rr_gap g%0d: got out_valid=%b expected 00", g, ov);
            end
        end
    endtask

    task automatic test_fixed_starvation();
        do_reset();
        src_valid = 4'b1010;
        out_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            #1;
            tick();
            n_vec++;
            if (gid[0] !== 2'd1 || gid[1] !== ((g % 2) ? 2'd3 : 2'd1)) begin
                n_err++;
                $display("FAIL starvation g%0d: got fx=%0d rr=%0d expected fx=1 rr=%0d",
                         g, gid[0], gid[1], (g % 2) ? 3 : 1);
            end
            tick();
        end
    endtask

    task automatic test_enable();
        do_reset();
        src_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        n_vec++;
        if (ov !== 2'b11) begin
            n_err++;
            $display("FAIL enable_inflight: got out_valid=%b expected 11", ov);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (ov !== 2'b00) begin
            n_err++;
            $display("FAIL enable_complete: got out_valid=%b expected 00", ov);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (ov !== 2'b00 || sr !== 8'b0) begin
                n_err++;
                $display("FAIL enable_blocked c%0d: got ov=%b sr=%b expected 00 0", c, ov, sr);
            end
        end
        enable = 1'b1;
        #1;
        n_vec++;
        if (sr !== {4'b0001, 4'b0001}) begin
            n_err++;
            $display("FAIL enable_resume: got sr=%b expected 00010001", sr);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        src_data  = {32'h0, 32'h7777_0002, 32'h0, 32'h0};
        src_valid = 4'b0100;
        out_ready = 1'b0;
        tick();
        n_vec++;
        if (ov !== 2'b11) begin
            n_err++;
            $display("FAIL midsend_pre: got out_valid=%b expected 11", ov);
        end
        #2;
        rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_vec++;
            if ({ov[m], bz[m], od[m], gid[m]} !== 36'd0) begin
                n_err++;
                $display("FAIL midsend_async[%0d]: got ov=%b bz=%b od=%h gid=%0d expected all zero",
                         m, ov[m], bz[m], od[m], gid[m]);
            end
        end
        src_valid = 4'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        int          st[2];
        logic [31:0] word[2];
        int          id[2];
        int          w[2];
        int          ptr;
        do_reset();
        st   = '{0, 0};
        word = '{32'h0, 32'h0};
        id   = '{0, 0};
        ptr  = 0;
        for (int c = 0; c < 400; c++) begin
            src_valid = 4'($urandom);
            src_data  = {$urandom, $urandom, $urandom, $urandom};
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            for (int m = 0; m < 2; m++) begin
                logic [3:0] exp_sr;
                w[m] = (st[m] == 0 && enable && (|src_valid)) ? pick(src_valid, (m == 1) ? ptr : 0) : -1;
                exp_sr = (w[m] >= 0) ? 4'(1 << w[m]) : 4'b0;
                n_vec++;
                if (sr[m] !== exp_sr) begin
                    n_err++;
                    $display("FAIL random_ready[%0d] c%0d: got %b expected %b", m, c, sr[m], exp_sr);
                end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (w[m] >= 0) begin
                    st[m]   = 1;
                    word[m] = src_data[w[m]*32 +: 32];
                    id[m]   = w[m];
                    if (m == 1) ptr = (w[m] + 1) % 4;
                end else if (st[m] == 1 && out_ready) begin
                    st[m] = 0;
                end
                n_vec++;
                if ({ov[m], bz[m], od[m], gid[m]} !== {1'(st[m]), 1'(st[m]), word[m], 2'(id[m])}) begin
                    n_err++;
                    $display("FAIL random_out[%0d] c%0d: got ov=%b bz=%b od=%h gid=%0d expected %0d %0d %h %0d",
                             m, c, ov[m], bz[m], od[m], gid[m], st[m], st[m], word[m], id[m]);
                end
            end
        end
        src_valid = 4'b0;
        enable    = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        src_valid = 4'b0;
        src_data  = '0;
        test_reset();
        test_single_channel();
        test_backpressure();
        test_rr_fairness();
        test_fixed_starvation();
        test_enable();
        test_reset_mid_send();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
